// File: rtl/n64adv_vparams.sv
// Shared N64 video constants: colour width, sync-bit positions, pixel phase encoding.
// Pure definitions, no logic, no latency, no flow control.
package n64adv_vparams;

   localparam int COLOR_W_DEF = 7;
   localparam int SYNC_W      = 4;

   // Layout of VD_i[3:0] during the sync phase: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
   localparam int SYNC_VS = 3;
   localparam int SYNC_CL = 2;
   localparam int SYNC_HS = 1;
   localparam int SYNC_CS = 0;

   localparam logic [SYNC_W-1:0] SYNC_IDLE = 4'hF;

   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_R    = 2'd1,
      PH_G    = 2'd2,
      PH_B    = 2'd3
   } phase_t;

   function automatic logic sync_fell(input logic [SYNC_W-1:0] prev,
                                      input logic [SYNC_W-1:0] cur,
                                      input int                idx);
      return prev[idx] & ~cur[idx];
   endfunction

endpackage

// File: rtl/n64adv_vmode_detect.sv
// Line counting and PAL / field / interlace detection from sync-phase samples.
// Outputs update the cycle after a qualifying vsync fall; no backpressure.
module n64adv_vmode_detect
   import n64adv_vparams::*;
#(
   parameter int LINE_CNT_W  = 10,
   parameter int PAL_LINE_TH = 288
) (
   input  logic              VCLK,
   input  logic              nVRST,
   input  logic              i_sync_vld,
   input  logic [SYNC_W-1:0] i_sync,
   output logic              o_pal,
   output logic              o_field,
   output logic              o_interlaced
);

   localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
   localparam logic [LINE_CNT_W-1:0] LINE_ONE = {{(LINE_CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_W-1:0]     r_hist;
   logic [LINE_CNT_W-1:0] r_line_cnt;
   logic                  r_pal;
   logic                  r_field;
   logic                  r_interlaced;

   logic w_vs_fall;
   logic w_hs_fall;

   assign w_vs_fall = sync_fell(r_hist, i_sync, SYNC_VS);
   assign w_hs_fall = sync_fell(r_hist, i_sync, SYNC_HS);

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_hist       <= SYNC_IDLE;
         r_line_cnt   <= '0;
         r_pal        <= 1'b0;
         r_field      <= 1'b0;
         r_interlaced <= 1'b0;
      end else if (i_sync_vld) begin
         r_hist <= i_sync;
         // A vsync fall closes the field; an hsync fall on the same sample is not a line.
         if (w_vs_fall) begin
            r_pal        <= (32'(r_line_cnt) > 32'(PAL_LINE_TH));
            r_field      <= i_sync[SYNC_HS];
            r_interlaced <= (i_sync[SYNC_HS] != r_field);
            r_line_cnt   <= '0;
         end else if (w_hs_fall && (r_line_cnt != LINE_MAX)) begin
            r_line_cnt <= r_line_cnt + LINE_ONE;
         end
      end
   end

   assign o_pal        = r_pal;
   assign o_field      = r_field;
   assign o_interlaced = r_interlaced;

endmodule

// File: rtl/n64adv_vdemux.sv
// Demultiplexes the 4-phase N64 video bus into {sync,R,G,B} pixels with phase-error tracking.
// vdata_valid_o rises 1 VCLK after the B sample; the source cannot be stalled.
module n64adv_vdemux
   import n64adv_vparams::*;
#(
   parameter int COLOR_W     = COLOR_W_DEF,
   parameter int LINE_CNT_W  = 10,
   parameter int PAL_LINE_TH = 288,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                          VCLK,
   input  logic                          nVRST,
   input  logic                          nVDSYNC,
   input  logic [COLOR_W-1:0]            VD_i,
   output logic [SYNC_W+3*COLOR_W-1:0]   vdata_o,
   output logic                          vdata_valid_o,
   output logic                          pal_o,
   output logic                          interlaced_o,
   output logic                          field_o,
   output logic [ERR_CNT_W-1:0]          phase_err_o,
   input  logic                          err_clr_i
);

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   phase_t                        r_phase;
   logic                          r_locked;
   logic [SYNC_W-1:0]             r_sync;
   logic [COLOR_W-1:0]            r_red;
   logic [COLOR_W-1:0]            r_grn;
   logic [SYNC_W+3*COLOR_W-1:0]   r_vdata;
   logic                          r_vdata_vld;
   logic [ERR_CNT_W-1:0]          r_err;

   logic              w_sync_ph;
   logic              w_early;
   logic              w_missing;
   logic              w_b_edge;
   logic [SYNC_W-1:0] w_sync_smp;

   assign w_sync_ph  = ~nVDSYNC;
   assign w_sync_smp = VD_i[SYNC_W-1:0];
   assign w_early    = w_sync_ph & (r_phase != PH_B);
   // Until the first sync after reset there is no pixel stream to be out of step with.
   assign w_missing  = ~w_sync_ph & (r_phase == PH_B) & r_locked;
   assign w_b_edge   = ~w_sync_ph & (r_phase == PH_G);

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_phase     <= PH_B;
         r_locked    <= 1'b0;
         r_sync      <= SYNC_IDLE;
         r_red       <= '0;
         r_grn       <= '0;
         r_vdata     <= {SYNC_IDLE, {(3*COLOR_W){1'b0}}};
         r_vdata_vld <= 1'b0;
      end else begin
         r_vdata_vld <= w_b_edge;
         if (w_sync_ph) begin
            r_phase  <= PH_SYNC;
            r_locked <= 1'b1;
            r_sync   <= w_sync_smp;
         end else if (r_phase != PH_B) begin
            r_phase <= phase_t'(r_phase + 2'd1);
         end
         if (!w_sync_ph && (r_phase == PH_SYNC)) r_red <= VD_i;
         if (!w_sync_ph && (r_phase == PH_R))    r_grn <= VD_i;
         if (w_b_edge) r_vdata <= {r_sync, r_red, r_grn, VD_i};
      end
   end

   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_err <= '0;
      end else if (err_clr_i) begin
         r_err <= '0;
      end else if ((w_early || w_missing) && (r_err != ERR_MAX)) begin
         r_err <= r_err + ERR_ONE;
      end
   end

   n64adv_vmode_detect #(
      .LINE_CNT_W  (LINE_CNT_W),
      .PAL_LINE_TH (PAL_LINE_TH)
   ) u_vmode (
      .VCLK         (VCLK),
      .nVRST        (nVRST),
      .i_sync_vld   (w_sync_ph),
      .i_sync       (w_sync_smp),
      .o_pal        (pal_o),
      .o_field      (field_o),
      .o_interlaced (interlaced_o)
   );

   assign vdata_o       = r_vdata;
   assign vdata_valid_o = r_vdata_vld;
   assign phase_err_o   = r_err;

endmodule

// File: tb/tb_n64adv_vdemux.sv
// Directed bench for n64adv_vdemux: pixel demux, phase errors, PAL/field/interlace, reset.
module tb_n64adv_vdemux;

   logic        VCLK;
   logic        nVRST;
   logic        nVDSYNC;
   logic [6:0]  VD_i;
   logic [24:0] vdata_o;
   logic        vdata_valid_o;
   logic        pal_o;
   logic        interlaced_o;
   logic        field_o;
   logic [7:0]  phase_err_o;
   logic        err_clr_i;

   int total = 0;
   int bad   = 0;

   n64adv_vdemux #(
      .COLOR_W     (7),
      .LINE_CNT_W  (10),
      .PAL_LINE_TH (288),
      .ERR_CNT_W   (8)
   ) dut (
      .VCLK          (VCLK),
      .nVRST         (nVRST),
      .nVDSYNC       (nVDSYNC),
      .VD_i          (VD_i),
      .vdata_o       (vdata_o),
      .vdata_valid_o (vdata_valid_o),
      .pal_o         (pal_o),
      .interlaced_o  (interlaced_o),
      .field_o       (field_o),
      .phase_err_o   (phase_err_o),
      .err_clr_i     (err_clr_i)
   );

   initial VCLK = 1'b0;
   always #5 VCLK = ~VCLK;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, observed, expected);
      end
   endtask

   // Inputs change at the falling edge; return 1 ns after the rising edge that sampled them.
   task automatic drive(input logic nvd, input logic [6:0] vd);
      @(negedge VCLK);
      nVDSYNC = nvd;
      VD_i    = vd;
      @(posedge VCLK);
      #1;
   endtask

   task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
      drive(1'b0, {3'b000, s});
      drive(1'b1, r);
      drive(1'b1, g);
      drive(1'b1, b);
   endtask

   task automatic sync_px(input logic [3:0] s);
      pixel(s, 7'h00, 7'h00, 7'h00);
   endtask

   task automatic lines(input int n);
      for (int i = 0; i < n; i++) begin
         sync_px(4'hF);
         sync_px(4'hD);
      end
   endtask

   task automatic vfall(input logic hs);
      sync_px(4'hF);
      sync_px({1'b0, 1'b1, hs, 1'b1});
   endtask

   initial begin
      nVRST     = 1'b0;
      nVDSYNC   = 1'b1;
      VD_i      = 7'h00;
      err_clr_i = 1'b0;
      repeat (3) @(posedge VCLK);
      #1;
      chk("rst_vdata", 32'(vdata_o), 32'({4'hF, 21'h0}));
      chk("rst_valid", 32'(vdata_valid_o), 32'd0);
      chk("rst_pal",   32'(pal_o), 32'd0);
      chk("rst_il",    32'(interlaced_o), 32'd0);
      chk("rst_field", 32'(field_o), 32'd0);
      chk("rst_err",   32'(phase_err_o), 32'd0);

      @(negedge VCLK);
      nVRST = 1'b1;
      drive(1'b1, 7'h00);
      drive(1'b1, 7'h00);
      chk("idle_err", 32'(phase_err_o), 32'd0);

      pixel(4'hF, 7'h11, 7'h22, 7'h33);
      chk("px1_valid", 32'(vdata_valid_o), 32'd1);
      chk("px1_data",  32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));
      chk("px1_err",   32'(phase_err_o), 32'd0);

      // Early sync at phase 2 discards R/G and restarts the pixel.
      drive(1'b0, 7'h0F);
      chk("px1_strobe_1cyc", 32'(vdata_valid_o), 32'd0);
      drive(1'b1, 7'h05);
      drive(1'b1, 7'h06);
      drive(1'b0, 7'h0F);
      chk("early_valid", 32'(vdata_valid_o), 32'd0);
      chk("early_err",   32'(phase_err_o), 32'd1);
      drive(1'b1, 7'h44);
      drive(1'b1, 7'h55);
      chk("early_no_strobe", 32'(vdata_valid_o), 32'd0);
      drive(1'b1, 7'h66);
      chk("recov_valid", 32'(vdata_valid_o), 32'd1);
      chk("recov_data",  32'(vdata_o), 32'({4'hF, 7'h44, 7'h55, 7'h66}));

      vfall(1'b0);
      chk("vf0_pal",   32'(pal_o), 32'd0);
      chk("vf0_field", 32'(field_o), 32'd0);
      chk("vf0_il",    32'(interlaced_o), 32'd0);

      lines(313);
      chk("pal_hold_until_vs", 32'(pal_o), 32'd0);
      vfall(1'b0);
      chk("pal_313", 32'(pal_o), 32'd1);
      chk("il_const", 32'(interlaced_o), 32'd0);

      lines(263);
      vfall(1'b0);
      chk("pal_263", 32'(pal_o), 32'd0);

      lines(289);
      vfall(1'b0);
      chk("pal_289", 32'(pal_o), 32'd1);

      lines(288);
      vfall(1'b0);
      chk("pal_288", 32'(pal_o), 32'd0);

      lines(2);
      vfall(1'b1);
      chk("alt1_field", 32'(field_o), 32'd1);
      chk("alt1_il",    32'(interlaced_o), 32'd1);
      lines(2);
      vfall(1'b0);
      chk("alt2_field", 32'(field_o), 32'd0);
      chk("alt2_il",    32'(interlaced_o), 32'd1);
      lines(2);
      vfall(1'b1);
      chk("alt3_field", 32'(field_o), 32'd1);
      chk("alt3_il",    32'(interlaced_o), 32'd1);
      lines(2);
      vfall(1'b1);
      chk("same_field", 32'(field_o), 32'd1);
      chk("same_il",    32'(interlaced_o), 32'd0);
      chk("clean_stream_err", 32'(phase_err_o), 32'd1);

      err_clr_i = 1'b1;
      pixel(4'hF, 7'h01, 7'h02, 7'h03);
      err_clr_i = 1'b0;
      chk("clr_err", 32'(phase_err_o), 32'd0);
      for (int i = 0; i < 300; i++) drive(1'b1, 7'h00);
      chk("sat_err",   32'(phase_err_o), 32'd255);
      chk("sat_valid", 32'(vdata_valid_o), 32'd0);
      err_clr_i = 1'b1;
      drive(1'b1, 7'h00);
      chk("clr_prio", 32'(phase_err_o), 32'd0);
      err_clr_i = 1'b0;
      drive(1'b1, 7'h00);
      chk("missing_resume", 32'(phase_err_o), 32'd1);

      // Reset mid-pixel (phase 1) with non-reset values in flight.
      drive(1'b0, 7'h0F);
      drive(1'b1, 7'h2A);
      @(negedge VCLK);
      nVRST = 1'b0;
      #1;
      chk("arst_vdata", 32'(vdata_o), 32'({4'hF, 21'h0}));
      chk("arst_valid", 32'(vdata_valid_o), 32'd0);
      chk("arst_field", 32'(field_o), 32'd0);
      chk("arst_pal",   32'(pal_o), 32'd0);
      chk("arst_il",    32'(interlaced_o), 32'd0);
      chk("arst_err",   32'(phase_err_o), 32'd0);
      @(negedge VCLK);
      nVRST = 1'b1;
      drive(1'b1, 7'h2B);
      drive(1'b1, 7'h2C);
      drive(1'b1, 7'h2D);
      chk("post_rst_err", 32'(phase_err_o), 32'd0);
      chk("post_rst_nostrobe", 32'(vdata_valid_o), 32'd0);
      pixel(4'hF, 7'h0A, 7'h0B, 7'h0C);
      chk("post_rst_valid", 32'(vdata_valid_o), 32'd1);
      chk("post_rst_data",  32'(vdata_o), 32'({4'hF, 7'h0A, 7'h0B, 7'h0C}));
      chk("post_rst_err2",  32'(phase_err_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
